// File: rtl/dummy_adc_if.sv
// FIFO write-side bus between the capture block and the slot's circular FIFO.
// The block writes bytes; the FIFO owns both 11-bit pointers.
interface dummy_adc_if;
  logic        fifo_clk;
  logic [7:0]  fifo_data;
  logic        fifo_write;
  logic [10:0] fifo_addr_in;
  logic [10:0] fifo_addr_out;

  modport master (
    output fifo_clk, fifo_data, fifo_write,
    input  fifo_addr_in, fifo_addr_out
  );

  modport slave (
    input  fifo_clk, fifo_data, fifo_write,
    output fifo_addr_in, fifo_addr_out
  );
endinterface

// File: rtl/dummy_adc.sv
// Stand-in ADC: deserializes a data/LRCK/BCK stream into {right,left} words
// and writes each word as four bytes into the slot FIFO, dropping whole samples when full.
module dummy_adc #(
  parameter int SAMPLE_BITS = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  slot_data,
  input  logic        direction,
  input  logic        channels,
  dummy_adc_if.master fif,
  output logic [7:0]  overflow_count,
  output logic        frame_error
);

  localparam int WW = 2 * SAMPLE_BITS;
  localparam int CW = $clog2(SAMPLE_BITS + 2);
  localparam logic [CW-1:0] CNT_FULL = CW'(SAMPLE_BITS);
  localparam logic [CW-1:0] CNT_SAT  = CW'(SAMPLE_BITS + 1);

  typedef enum logic [1:0] {C_ARM, C_LEFT, C_RIGHT} cap_state_t;
  typedef enum logic [2:0] {W_IDLE, W_B0, W_B1, W_B2, W_B3} wr_state_t;

  logic unused_in;
  assign unused_in = ^{channels, slot_data[5:3]};

  assign fif.fifo_clk = clk;

  // ---------------- input synchronizer + registered edge pulses
  logic [SYNC_STAGES-1:0][2:0] sync_q;
  logic [2:0] sync_out, hist_q;
  logic       bck_rise, lrck_rise, lrck_fall;

  assign sync_out = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q    <= '0;
      hist_q    <= '0;
      bck_rise  <= 1'b0;
      lrck_rise <= 1'b0;
      lrck_fall <= 1'b0;
    end else begin
      sync_q[0] <= slot_data[2:0];
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      hist_q    <= sync_out;
      bck_rise  <= sync_out[2] & ~hist_q[2];
      lrck_rise <= sync_out[1] & ~hist_q[1];
      lrck_fall <= ~sync_out[1] & hist_q[1];
    end
  end

  // hist_q[0] is the data bit sampled alongside the BCK level that produced bck_rise
  logic [SAMPLE_BITS-1:0] shift_q, shift_nx, left_q;
  logic [CW-1:0]          cnt_q, cnt_nx, lcnt_q;

  always_comb begin
    shift_nx = shift_q;
    cnt_nx   = cnt_q;
    if (bck_rise) begin
      if (cnt_q < CNT_FULL) shift_nx = {hist_q[0], shift_q[SAMPLE_BITS-1:1]};
      if (cnt_q != CNT_SAT) cnt_nx = cnt_q + 1'b1;
    end
  end

  // ---------------- capture FSM
  cap_state_t cap_state;
  logic       frame_ok, commit_req;
  logic [WW-1:0] word_nx;

  assign frame_ok   = (lcnt_q == CNT_FULL) && (cnt_nx == CNT_FULL);
  assign commit_req = direction && (cap_state == C_RIGHT) && lrck_rise && frame_ok;
  assign word_nx    = {shift_nx, left_q};

  always_ff @(posedge clk) begin
    if (reset) begin
      cap_state   <= C_ARM;
      shift_q     <= '0;
      cnt_q       <= '0;
      left_q      <= '0;
      lcnt_q      <= '0;
      frame_error <= 1'b0;
    end else begin
      frame_error <= 1'b0;
      shift_q     <= shift_nx;
      cnt_q       <= cnt_nx;
      if (!direction) begin
        cap_state <= C_ARM;
        shift_q   <= '0;
        cnt_q     <= '0;
      end else begin
        case (cap_state)
          C_ARM: if (lrck_rise) begin
            cap_state <= C_LEFT;
            shift_q   <= '0;
            cnt_q     <= '0;
          end
          C_LEFT: if (lrck_fall) begin
            // shift_nx/cnt_nx already include a BCK bit landing in this same cycle
            left_q    <= shift_nx;
            lcnt_q    <= cnt_nx;
            shift_q   <= '0;
            cnt_q     <= '0;
            cap_state <= C_RIGHT;
          end
          C_RIGHT: if (lrck_rise) begin
            shift_q     <= '0;
            cnt_q       <= '0;
            cap_state   <= C_LEFT;
            frame_error <= ~frame_ok;
          end
          default: cap_state <= C_ARM;
        endcase
      end
    end
  end

  // ---------------- byte writer
  wr_state_t     wr_state;
  logic [WW-1:0] word_q;
  logic [10:0]   free;
  logic          room;

  assign free = fif.fifo_addr_out - fif.fifo_addr_in - 11'd1;
  assign room = free >= 11'd4;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_state       <= W_IDLE;
      word_q         <= '0;
      fif.fifo_data  <= '0;
      fif.fifo_write <= 1'b0;
      overflow_count <= '0;
    end else begin
      // a sample that cannot start a burst right now is dropped whole
      if (commit_req && !(room && wr_state == W_IDLE) && overflow_count != 8'hFF)
        overflow_count <= overflow_count + 8'd1;
      case (wr_state)
        W_IDLE: if (commit_req && room) begin
          word_q         <= word_nx;
          fif.fifo_data  <= word_nx[7:0];
          fif.fifo_write <= 1'b1;
          wr_state       <= W_B0;
        end
        W_B0: begin
          fif.fifo_data <= word_q[15:8];
          wr_state      <= W_B1;
        end
        W_B1: begin
          fif.fifo_data <= word_q[23:16];
          wr_state      <= W_B2;
        end
        W_B2: begin
          fif.fifo_data <= word_q[31:24];
          wr_state      <= W_B3;
        end
        W_B3: begin
          fif.fifo_data  <= '0;
          fif.fifo_write <= 1'b0;
          wr_state       <= W_IDLE;
        end
        default: begin
          fif.fifo_write <= 1'b0;
          wr_state       <= W_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/dummy_adc.md
# dummy_adc

Capture-side counterpart of the slot serial DAC path. Receives the 3-wire serial audio stream (data, LRCK, BCK) on a slot's `slot_data` lines and deserializes left/right half-frames into 32-bit samples. Writes each sample as 4 bytes into the slot's circular FIFO using the FIFO's 11-bit address pointers. Used by the cosim firmware as a stand-in ADC and as a loopback checker for the DAC serializer.

## Interface
Parameters:
- `SAMPLE_BITS`, 16, bits per half-frame (left or right); sample word = {right, left}, 2×SAMPLE_BITS = 32.
- `SYNC_STAGES`, 2, flip-flop stages on each incoming slot line.

Ports:
- `clk`  in  1  system clock; all logic on rising edge. One clock; reset is synchronous and active-high.
- `reset`  in  1  synchronous, active-high reset.
- `slot_data`  in  6  [0]=serial data, [1]=LRCK (1=left), [2]=BCK; [5:3] ignored.
- `direction`  in  1  1=slot is input (capture enabled); 0=block idle.
- `channels`  in  1  reserved; ignored.
- `fifo_clk`  out  1  equals `clk`.
- `fifo_data`  out  8  byte to write.
- `fifo_write`  out  1  write strobe, one byte per cycle while high.
- `fifo_addr_in`  in  11  FIFO write pointer (advanced by FIFO on each write).
- `fifo_addr_out`  in  11  FIFO read pointer.
- `overflow_count`  out  8  samples dropped (FIFO full or writer busy), saturates at 255.
- `frame_error`  out  1  one-cycle pulse when a half-frame bit count ≠ SAMPLE_BITS.

## Operation
- `slot_data[2:0]` pass through SYNC_STAGES FFs, then one history FF for edge detection. Data bit is taken from the same synchronized stage as BCK.
- BCK rising edge (synced): shift data bit into current half register, LSB first. Bit counter saturates at SAMPLE_BITS+1. Bits beyond SAMPLE_BITS are ignored.
- Capture FSM:
  - ARM: entered from reset or whenever `direction`=0. Waits for LRCK rising edge, then goes to LEFT. No error flagged for a partial frame.
  - LEFT: on LRCK falling edge, latch left half and bit count, clear counter, go to RIGHT.
  - RIGHT: on LRCK rising edge, go to LEFT and evaluate the frame.
    - If both counts == SAMPLE_BITS: commit {right, left}.
    - Else: pulse `frame_error` and discard the frame.
  - An LRCK falling edge while in LEFT with count ≠ SAMPLE_BITS still moves to RIGHT; the error is reported at the following rising edge.
- Commit:
  - free = (`fifo_addr_out` − `fifo_addr_in` − 1) mod 2048.
  - If free ≥ 4 and writer is IDLE: load write register.
  - Otherwise drop the whole sample and increment `overflow_count` (saturating). No partial samples are ever written.
- Writer FSM: IDLE → B0 → B1 → B2 → B3 → IDLE.
  - `fifo_data` = word[7:0], [15:8], [23:16], [31:24] in B0..B3 respectively.
  - `fifo_write`=1 in B0..B3.
- `direction` falling mid-frame: capture returns to ARM and the frame is discarded. A writer burst already started completes.
- Reset mid-burst: writer aborts immediately; bytes already strobed stay in the FIFO.

## Timing
- Reset values: `fifo_write`=0, `fifo_data`=0, `overflow_count`=0, `frame_error`=0; capture FSM=ARM, writer=IDLE, shift registers and counters 0.
- Pin edge to internal edge detect: SYNC_STAGES+1 cycles (3 by default). BCK and LRCK must be stable ≥ 4 clk between edges.
- Commit cycle = cycle the LRCK rising edge is detected. B0 (first `fifo_write`) is the next cycle; 4 consecutive write cycles follow.
- Pin LRCK rise to first `fifo_write` = SYNC_STAGES+2 cycles.
- Free-space check uses pointer values in the commit cycle. Pointer wrap 2047→0 is handled by 11-bit modular subtraction.
- Simultaneous LRCK and BCK edges in the same cycle: the BCK bit is shifted into the outgoing half before the half is latched.

## Test plan
- Serialize left=0x1234, right=0xABCD (16 BCK/half, LSB first) after one arming LRCK rise → bytes 0x34, 0x12, 0xCD, 0xAB on 4 consecutive `fifo_write` cycles; first write 4 clk after pin LRCK rise.
- Loopback from the DAC serializer with FIFO words 0x00000000, 0xFFFFFFFF, 0xA5A55A5A → identical byte sequences captured, no `frame_error`.
- `fifo_addr_in`=2046, `fifo_addr_out`=2 (free 3) at commit → no writes, `overflow_count`=1. Repeat with `fifo_addr_out`=3 (free 4) → 4 writes.
- Left half with 15 BCK edges → one `frame_error` pulse at next LRCK rise, no writes. Next correct frame is written normally.
- Drop `direction` mid-RIGHT, restore it, then send 2 frames → first post-restore LRCK rise only arms; exactly one sample (4 bytes) written.
- Assert `reset` during B1 → `fifo_write`=0 the next cycle; `overflow_count`=0; the following full frame is captured correctly after re-arming.
